dm9000_bus_arbiter: RTL and testbench
=====================================

DM9000_BUS_ARBITER -- requirements
Module: dm9000_bus_arbiter

Interface
REQ-001 SHALL have parameter STROBE_CYC, default 2: CLOCK_50 cycles that ENET_WR_N/ENET_RD_N are held low per phase (legal 1..15).
REQ-002 SHALL have parameter RECOV_CYC, default 2: CLOCK_50 cycles of strobe-high recovery after each phase (legal 1..15).
REQ-003 SHALL have one clock, CLOCK_50, and one reset, RST_N; reset is asynchronous and active-low.
REQ-004 Port CLOCK_50, input, 1 bit: 50 MHz clock; all state updates on its rising edge.
REQ-005 Port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-006 Port REQ, input, 2 bits: per-requester access request; bit 0 is config/init, bit 1 is packet datapath; held high until that requester's ACK.
REQ-007 Port WR, input, 2 bits: per-requester direction; 1 is write, 0 is read.
REQ-008 Port ADDR, input, 16 bits: DM9000A register index; [7:0] is requester 0, [15:8] is requester 1.
REQ-009 Port WDATA, input, 32 bits: write data; [15:0] is requester 0, [31:16] is requester 1.
REQ-010 Port ACK, output, 2 bits: one-cycle completion pulse to the granted requester.
REQ-011 Port RDATA, output, 16 bits: read data; valid in the ACK cycle and held until the next read completes.
REQ-012 Port BUSY, output, 1 bit: high whenever the state machine is not IDLE.
REQ-013 Ports ENET_CMD, ENET_CS_N, ENET_WR_N and ENET_RD_N, outputs, 1 bit each: DM9000A bus controls.
REQ-014 Ports ENET_DATA_O (output, 16), ENET_DATA_OE (output, 1) and ENET_DATA_I (input, 16): split tri-state data bus; the top level builds the pad.

Function
REQ-015 SHALL use the states IDLE, IDX_STB, IDX_REC, DAT_STB, DAT_REC and ACK.
REQ-016 In IDLE with any REQ bit high, SHALL grant one requester, latch its WR/ADDR/WDATA, and move to IDX_STB next cycle; latched fields SHALL NOT change until ACK.
REQ-017 Index skip: if the index-cache valid flag is set and the latched ADDR equals the cached index, SHALL go IDLE→DAT_STB, skipping both index phases.
REQ-018 IDX_STB: ENET_CS_N=0, ENET_CMD=0, ENET_WR_N=0, ENET_DATA_OE=1, ENET_DATA_O={8'h00,ADDR} for STROBE_CYC cycles, then IDX_REC.
REQ-019 IDX_REC: ENET_WR_N=1, ENET_CS_N=1, ENET_DATA_OE=0 for RECOV_CYC cycles, then DAT_STB; on entering IDX_REC the cached index SHALL be updated and the valid flag set.
REQ-020 DAT_STB: ENET_CS_N=0, ENET_CMD=1, with either (a) write: ENET_WR_N=0, ENET_DATA_OE=1, ENET_DATA_O=WDATA; or (b) read: ENET_RD_N=0, ENET_DATA_OE=0. Held for STROBE_CYC cycles.
REQ-021 Reads: SHALL register ENET_DATA_I into RDATA on the final DAT_STB cycle.
REQ-022 DAT_REC: strobes high, CS_N=1, OE=0 for RECOV_CYC cycles, then ACK.
REQ-023 ACK: exactly one cycle with ACK[granted]=1, then IDLE; minimum spacing between consecutive grants is therefore one IDLE cycle.
REQ-024 ENET_WR_N and ENET_RD_N SHALL never be low in the same cycle, and ENET_DATA_OE SHALL be 0 whenever ENET_RD_N=0.
REQ-025 All ENET_* outputs SHALL be registered; no combinational path from REQ to the bus pins.
REQ-026 Phase counters SHALL be 4 bits and reload on every state entry.
REQ-027 A REQ bit dropped before ACK is a protocol violation: the in-flight access SHALL still complete and ACK SHALL still pulse.

Reset
REQ-028 On RST_N low, asynchronously: state=IDLE, ACK=0, RDATA=0, BUSY=0, ENET_CS_N=1, ENET_WR_N=1, ENET_RD_N=1, ENET_CMD=0, ENET_DATA_OE=0, ENET_DATA_O=0, index valid=0.
REQ-029 Reset mid-access SHALL abort without an ACK pulse; the first access after reset SHALL always perform the index phase.

Configuration
REQ-030 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous REQ the grant SHALL go to the requester not granted last; the last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-031 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins ties.

Verification
REQ-032 Defaults; requester 0 writes ADDR=8'hFE, WDATA=16'h003F → index phase with DATA=00FE and CMD=0, then data phase with DATA=003F and CMD=1; each WR_N low for 2 cycles; ACK[0] 9 cycles after the grant.
REQ-033 Back-to-back writes from requester 1 to ADDR 8'hF8 → second access has no CMD=0 phase and ACK arrives 5 cycles after the grant.
REQ-034 Read of ADDR 8'h28 with ENET_DATA_I=16'h0A46 → RDATA=16'h0A46 in the ACK cycle; DATA_OE=0 throughout the data phase.
REQ-035 REQ=2'b11 held for four accesses → with ARB_ROUND_ROBIN_EN grants are 0,1,0,1; without it grants are 0,0,0,0 until REQ[0] drops.
REQ-036 RST_N pulsed low during DAT_STB → all strobes high immediately, no ACK, next access to the same ADDR performs the index phase.

Source files
------------

// File: rtl/dm9000_bus_arbiter.sv
// Two-requester arbiter driving the DM9000A host bus: an index phase (CMD=0), then a data phase (CMD=1).
// Define ARB_ROUND_ROBIN_EN for alternating grants on ties; otherwise requester 0 has fixed priority.
module dm9000_bus_arbiter #(
   parameter int unsigned STROBE_CYC = 2,
   parameter int unsigned RECOV_CYC  = 2
) (
   input  logic        CLOCK_50,
   input  logic        RST_N,
   input  logic [1:0]  REQ,
   input  logic [1:0]  WR,
   input  logic [15:0] ADDR,
   input  logic [31:0] WDATA,
   output logic [1:0]  ACK,
   output logic [15:0] RDATA,
   output logic        BUSY,
   output logic        ENET_CMD,
   output logic        ENET_CS_N,
   output logic        ENET_WR_N,
   output logic        ENET_RD_N,
   output logic [15:0] ENET_DATA_O,
   output logic        ENET_DATA_OE,
   input  logic [15:0] ENET_DATA_I
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_IDX_STB = 3'd1;
   localparam logic [2:0] S_IDX_REC = 3'd2;
   localparam logic [2:0] S_DAT_STB = 3'd3;
   localparam logic [2:0] S_DAT_REC = 3'd4;
   localparam logic [2:0] S_ACK     = 3'd5;

   localparam logic [3:0] STB_LOAD = 4'(STROBE_CYC - 1);
   localparam logic [3:0] REC_LOAD = 4'(RECOV_CYC - 1);

   logic [2:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        gnt_q, gnt_d;
   logic        wr_q, wr_d;
   logic [7:0]  addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [7:0]  idx_q, idx_d;
   logic        idx_vld_q, idx_vld_d;
   logic [15:0] rdata_q, rdata_d;
   logic [1:0]  ack_q, ack_d;
   logic        busy_q, busy_d;
   logic        cmd_q, cmd_d, cs_n_q, cs_n_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d, oe_q, oe_d;
   logic [15:0] dout_q, dout_d;
   logic        pick_s;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_q, last_d;

   // Ties go to the requester not granted last; the pointer resets to 1 so requester 0 wins first.
   always_comb begin
      if (REQ == 2'b11) begin
         pick_s = ~last_q;
      end else begin
         pick_s = REQ[1];
      end
      if ((state_q == S_IDLE) && (REQ != 2'b00)) begin
         last_d = pick_s;
      end else begin
         last_d = last_q;
      end
   end

   // Last-grant pointer register.
   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   // Fixed priority: requester 0 whenever it asks.
   always_comb begin
      pick_s = ~REQ[0];
   end
`endif

   // Sequencer: grant/latch in IDLE, walk the phases, maintain the index cache and read data.
   always_comb begin
      state_d   = state_q;
      cnt_d     = (cnt_q != 4'd0) ? (cnt_q - 4'd1) : 4'd0;
      gnt_d     = gnt_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      idx_d     = idx_q;
      idx_vld_d = idx_vld_q;
      rdata_d   = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (REQ != 2'b00) begin
               gnt_d   = pick_s;
               wr_d    = WR[pick_s];
               addr_d  = pick_s ? ADDR[15:8] : ADDR[7:0];
               wdata_d = pick_s ? WDATA[31:16] : WDATA[15:0];
               cnt_d   = STB_LOAD;
               if (idx_vld_q && (addr_d == idx_q)) begin
                  state_d = S_DAT_STB;
               end else begin
                  state_d = S_IDX_STB;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_IDX_STB: begin
            if (cnt_q == 4'd0) begin
               state_d   = S_IDX_REC;
               cnt_d     = REC_LOAD;
               idx_d     = addr_q;
               idx_vld_d = 1'b1;
            end else begin
               state_d = S_IDX_STB;
            end
         end
         S_IDX_REC: begin
            if (cnt_q == 4'd0) begin
               state_d = S_DAT_STB;
               cnt_d   = STB_LOAD;
            end else begin
               state_d = S_IDX_REC;
            end
         end
         S_DAT_STB: begin
            if (cnt_q == 4'd0) begin
               state_d = S_DAT_REC;
               cnt_d   = REC_LOAD;
               if (!wr_q) begin
                  rdata_d = ENET_DATA_I;
               end else begin
                  rdata_d = rdata_q;
               end
            end else begin
               state_d = S_DAT_STB;
            end
         end
         S_DAT_REC: begin
            if (cnt_q == 4'd0) begin
               state_d = S_ACK;
               cnt_d   = 4'd0;
            end else begin
               state_d = S_DAT_REC;
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Bus pins are decoded from the next state so the registered outputs line up with the state register.
   always_comb begin
      cmd_d  = 1'b0;
      cs_n_d = 1'b1;
      wr_n_d = 1'b1;
      rd_n_d = 1'b1;
      oe_d   = 1'b0;
      dout_d = 16'h0000;
      ack_d  = 2'b00;
      busy_d = (state_d != S_IDLE);
      case (state_d)
         S_IDX_STB: begin
            cs_n_d = 1'b0;
            wr_n_d = 1'b0;
            oe_d   = 1'b1;
            dout_d = {8'h00, addr_d};
         end
         S_DAT_STB: begin
            cs_n_d = 1'b0;
            cmd_d  = 1'b1;
            if (wr_d) begin
               wr_n_d = 1'b0;
               oe_d   = 1'b1;
               dout_d = wdata_d;
            end else begin
               rd_n_d = 1'b0;
            end
         end
         S_ACK: begin
            ack_d = gnt_d ? 2'b10 : 2'b01;
         end
         default: begin
            ack_d = 2'b00;
         end
      endcase
   end

   // State, latched request fields, cache and output registers.
   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         gnt_q     <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= 8'h00;
         wdata_q   <= 16'h0000;
         idx_q     <= 8'h00;
         idx_vld_q <= 1'b0;
         rdata_q   <= 16'h0000;
         ack_q     <= 2'b00;
         busy_q    <= 1'b0;
         cmd_q     <= 1'b0;
         cs_n_q    <= 1'b1;
         wr_n_q    <= 1'b1;
         rd_n_q    <= 1'b1;
         oe_q      <= 1'b0;
         dout_q    <= 16'h0000;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         idx_q     <= idx_d;
         idx_vld_q <= idx_vld_d;
         rdata_q   <= rdata_d;
         ack_q     <= ack_d;
         busy_q    <= busy_d;
         cmd_q     <= cmd_d;
         cs_n_q    <= cs_n_d;
         wr_n_q    <= wr_n_d;
         rd_n_q    <= rd_n_d;
         oe_q      <= oe_d;
         dout_q    <= dout_d;
      end
   end

   assign ACK          = ack_q;
   assign RDATA        = rdata_q;
   assign BUSY         = busy_q;
   assign ENET_CMD     = cmd_q;
   assign ENET_CS_N    = cs_n_q;
   assign ENET_WR_N    = wr_n_q;
   assign ENET_RD_N    = rd_n_q;
   assign ENET_DATA_O  = dout_q;
   assign ENET_DATA_OE = oe_q;
endmodule

// File: tb/tb_dm9000_bus_arbiter.sv
// Directed bench for dm9000_bus_arbiter at default STROBE_CYC/RECOV_CYC; honours ARB_ROUND_ROBIN_EN.
module tb_dm9000_bus_arbiter;
   logic        clk;
   logic        rst_n;
   logic [1:0]  req;
   logic [1:0]  wr;
   logic [15:0] addr;
   logic [31:0] wdata;
   logic [1:0]  ack;
   logic [15:0] rdata;
   logic        busy;
   logic        enet_cmd, enet_cs_n, enet_wr_n, enet_rd_n, enet_oe;
   logic [15:0] enet_do, enet_di;

   int total = 0;
   int bad   = 0;

   int          lat, idx_cyc, dwr_cyc, drd_cyc;
   logic [15:0] idx_data, dat_data, rd_at_ack;
   logic        rule_bad;
   logic [1:0]  ack_seen;

   dm9000_bus_arbiter dut (
      .CLOCK_50(clk), .RST_N(rst_n), .REQ(req), .WR(wr), .ADDR(addr), .WDATA(wdata),
      .ACK(ack), .RDATA(rdata), .BUSY(busy),
      .ENET_CMD(enet_cmd), .ENET_CS_N(enet_cs_n), .ENET_WR_N(enet_wr_n), .ENET_RD_N(enet_rd_n),
      .ENET_DATA_O(enet_do), .ENET_DATA_OE(enet_oe), .ENET_DATA_I(enet_di)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One access from requester r; BUSY cycles up to and including the ACK cycle give the latency.
   task automatic do_access(input int r, input logic w, input logic [7:0] a,
                            input logic [15:0] d, input logic keep);
      lat = 0; idx_cyc = 0; dwr_cyc = 0; drd_cyc = 0;
      idx_data = 16'hxxxx; dat_data = 16'hxxxx; rd_at_ack = 16'hxxxx;
      rule_bad = 1'b0; ack_seen = 2'b00;
      wr[r] = w;
      addr[8*r +: 8] = a;
      wdata[16*r +: 16] = d;
      req[r] = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (busy) lat++;
         if (!enet_cs_n && !enet_cmd && !enet_wr_n) begin idx_cyc++; idx_data = enet_do; end
         if (!enet_cs_n && enet_cmd && !enet_wr_n) begin dwr_cyc++; dat_data = enet_do; end
         if (!enet_rd_n) begin drd_cyc++; if (enet_oe) rule_bad = 1'b1; end
         if (!enet_wr_n && !enet_rd_n) rule_bad = 1'b1;
         if (ack != 2'b00) begin ack_seen = ack; rd_at_ack = rdata; break; end
      end
      if (!keep) req[r] = 1'b0;
   endtask

   task automatic wait_ack(output logic [1:0] a);
      a = 2'b00;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (ack != 2'b00) begin a = ack; break; end
      end
   endtask

   initial begin
      logic [1:0] g;
      logic [1:0] exp_g [4];
      logic       ack_any;
      rst_n = 1'b0; req = 2'b00; wr = 2'b00; addr = 16'h0000; wdata = 32'h0; enet_di = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", {30'd0, ack}, 32'd0);
      chk("rst_rdata", {16'd0, rdata}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_strobes", {27'd0, enet_cs_n, enet_wr_n, enet_rd_n, enet_cmd, enet_oe}, 32'b11100);
      chk("rst_dout", {16'd0, enet_do}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Write FE <= 003F from requester 0: full index + data sequence.
      do_access(0, 1'b1, 8'hFE, 16'h003F, 1'b0);
      chk("w1_lat", lat, 32'd9);
      chk("w1_idx_cyc", idx_cyc, 32'd2);
      chk("w1_idx_data", {16'd0, idx_data}, 32'h00FE);
      chk("w1_dat_cyc", dwr_cyc, 32'd2);
      chk("w1_dat_data", {16'd0, dat_data}, 32'h003F);
      chk("w1_ack", {30'd0, ack_seen}, 32'b01);
      chk("w1_rules", {31'd0, rule_bad}, 32'd0);

      // Back-to-back writes to F8 from requester 1: the second skips the index phase.
      do_access(1, 1'b1, 8'hF8, 16'h1234, 1'b1);
      chk("b1_lat", lat, 32'd9);
      chk("b1_ack", {30'd0, ack_seen}, 32'b10);
      do_access(1, 1'b1, 8'hF8, 16'h5678, 1'b0);
      chk("b2_lat", lat, 32'd5);
      chk("b2_idx_cyc", idx_cyc, 32'd0);
      chk("b2_dat_data", {16'd0, dat_data}, 32'h5678);
      chk("b2_ack", {30'd0, ack_seen}, 32'b10);

      // Read of 28 returning 0A46.
      enet_di = 16'h0A46;
      do_access(0, 1'b0, 8'h28, 16'h0000, 1'b0);
      chk("rd_lat", lat, 32'd9);
      chk("rd_idx_data", {16'd0, idx_data}, 32'h0028);
      chk("rd_rd_cyc", drd_cyc, 32'd2);
      chk("rd_wr_cyc", dwr_cyc, 32'd0);
      chk("rd_oe_rules", {31'd0, rule_bad}, 32'd0);
      chk("rd_rdata", {16'd0, rd_at_ack}, 32'h0A46);
      enet_di = 16'hFFFF;
      repeat (3) @(posedge clk);
      #1;
      chk("rd_rdata_hold", {16'd0, rdata}, 32'h0A46);

      // REQ dropped mid-access: the access still finishes with an ACK.
      wr[0] = 1'b1; addr[7:0] = 8'h28; req[0] = 1'b1;
      repeat (2) @(posedge clk);
      #1; req[0] = 1'b0;
      wait_ack(g);
      chk("drop_ack", {30'd0, g}, 32'b01);

      // Reset during the data strobe of a cached-index write.
      @(posedge clk); #1;
      wr[0] = 1'b1; addr[7:0] = 8'h28; wdata[15:0] = 16'hAAAA; req[0] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (!enet_cs_n && enet_cmd) break;
      end
      chk("mid_in_dat_stb", {30'd0, enet_cs_n, enet_cmd}, 32'b01);
      rst_n = 1'b0; #1;
      chk("mid_rst_strobes", {28'd0, enet_cs_n, enet_wr_n, enet_rd_n, enet_oe}, 32'b1110);
      chk("mid_rst_busy_ack", {29'd0, busy, ack}, 32'd0);
      req = 2'b00;
      @(negedge clk); rst_n = 1'b1;
      ack_any = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         ack_any = ack_any | (ack != 2'b00);
      end
      chk("mid_no_ack", {31'd0, ack_any}, 32'd0);
      do_access(0, 1'b1, 8'h28, 16'hBEEF, 1'b0);
      chk("post_rst_idx_cyc", idx_cyc, 32'd2);
      chk("post_rst_lat", lat, 32'd9);

      // Simultaneous requests held over four accesses.
`ifdef ARB_ROUND_ROBIN_EN
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
      exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
      @(posedge clk); #1;
      wr = 2'b11; addr = 16'h4040; wdata = 32'h2222_1111; req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wait_ack(g);
         chk($sformatf("tie_grant%0d", k), {30'd0, g}, {30'd0, exp_g[k]});
      end
`ifndef ARB_ROUND_ROBIN_EN
      req[0] = 1'b0;
      wait_ack(g);
      chk("tie_after_drop", {30'd0, g}, 32'b10);
`endif
      req = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      chk("end_idle", {31'd0, busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
